// File: rtl/nanosoc_padmux_pkg.sv
// Shared types and constants for the nanosoc pad-function multiplexer.
// Function IDs, per-pad FSM state encoding, gap counter width, width helper.
package nanosoc_padmux_pkg;

  typedef enum logic [1:0] {
    FUNC_GPIO   = 2'd0,
    FUNC_FT1248 = 2'd1,
    FUNC_UART   = 2'd2,
    FUNC_ALT3   = 2'd3
  } func_id_e;

  typedef enum logic {
    STEADY = 1'b0,
    GAP    = 1'b1
  } pad_state_e;

  localparam int CNT_W = 4;

  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nanosoc_padmux_pin.sv
// One pad: STEADY/GAP break-before-make FSM, registered output mux, input sync.
// Ports: we_i/sel_i (decoded write), func_o_i/func_oe_i (per-function), pad_*.
module nanosoc_padmux_pin
  import nanosoc_padmux_pkg::*;
#(
  parameter int NUM_FUNCS  = 4,
  parameter int GAP_CYCLES = 2,
  parameter int SEL_W      = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 test_mode_i,
  input  logic                 we_i,
  input  logic [SEL_W-1:0]     sel_i,
  input  logic [NUM_FUNCS-1:0] func_o_i,
  input  logic [NUM_FUNCS-1:0] func_oe_i,
  input  logic                 pad_i,
  output logic                 busy_o,
  output logic [SEL_W-1:0]     cur_sel_o,
  output logic                 func_in_o,
  output logic                 pad_o,
  output logic                 pad_e
);

  localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  pad_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] pend_q, pend_d;
  logic [SEL_W-1:0] cur_q, cur_d;
  logic             po_q, po_d;
  logic             pe_q, pe_d;
  logic [1:0]       sync_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    cur_d   = cur_q;
    unique case (state_q)
      STEADY: begin
        if (we_i && sel_i != cur_q) begin
          pend_d  = sel_i;
          cnt_d   = GAP_LD;
          state_d = GAP;
        end
      end
      GAP: begin
        if (we_i && sel_i != pend_q && sel_i == cur_q) begin
          // cancel: finish through one more gap cycle back to cur
          pend_d = cur_q;
          cnt_d  = ONE;
        end else if (we_i && sel_i != pend_q) begin
          pend_d = sel_i;
          cnt_d  = GAP_LD;
        end else if (cnt_q == ONE) begin
          cur_d   = pend_q;
          state_d = STEADY;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: state_d = STEADY;
    endcase
  end

  // next-state view so the driver drops in the cycle right after the write
  always_comb begin
    po_d = 1'b0;
    pe_d = 1'b0;
    if (test_mode_i) begin
      po_d = func_o_i[FUNC_GPIO];
      pe_d = func_oe_i[FUNC_GPIO];
    end else if (state_d == STEADY) begin
      po_d = func_o_i[cur_d];
      pe_d = func_oe_i[cur_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= STEADY;
      cnt_q   <= '0;
      pend_q  <= '0;
      cur_q   <= '0;
      po_q    <= 1'b0;
      pe_q    <= 1'b0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      cur_q   <= cur_d;
      po_q    <= po_d;
      pe_q    <= pe_d;
      sync_q  <= {sync_q[0], pad_i};
    end
  end

  assign busy_o    = (state_q == GAP);
  assign cur_sel_o = cur_q;
  assign func_in_o = sync_q[1];
  assign pad_o     = po_q;
  assign pad_e     = pe_q;

endmodule

// File: rtl/nanosoc_pad_mux.sv
// Pad-function mux top: write decode, reject pulse, optional lock, bus flattening.
// Optional macro NANOSOC_PADMUX_LOCK_EN adds cfg_lock_i / cfg_locked_o.
module nanosoc_pad_mux
  import nanosoc_padmux_pkg::*;
#(
  parameter  int NUM_PINS   = 16,
  parameter  int NUM_FUNCS  = 4,
  parameter  int GAP_CYCLES = 2,
  localparam int SEL_W      = min1_clog2(NUM_FUNCS),
  localparam int PIN_W      = min1_clog2(NUM_PINS)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          test_mode_i,
  input  logic                          cfg_we_i,
  input  logic [PIN_W-1:0]              cfg_pin_i,
  input  logic [SEL_W-1:0]              cfg_sel_i,
`ifdef NANOSOC_PADMUX_LOCK_EN
  input  logic                          cfg_lock_i,
  output logic                          cfg_locked_o,
`endif
  output logic                          cfg_err_o,
  output logic [NUM_PINS-1:0]           cfg_busy_o,
  output logic [NUM_PINS*SEL_W-1:0]     cur_sel_o,
  input  logic [NUM_FUNCS*NUM_PINS-1:0] func_o_i,
  input  logic [NUM_FUNCS*NUM_PINS-1:0] func_oe_i,
  output logic [NUM_PINS-1:0]           func_in_o,
  input  logic [NUM_PINS-1:0]           pad_i,
  output logic [NUM_PINS-1:0]           pad_o,
  output logic [NUM_PINS-1:0]           pad_e,
  output logic [NUM_PINS-1:0]           pad_z
);

  logic locked;
  logic pin_ok, sel_ok, wr_ok;
  logic err_q, err_d;

`ifdef NANOSOC_PADMUX_LOCK_EN
  logic lock_q, lock_d;

  // lock raised this cycle only blocks writes from the next cycle on
  assign lock_d = lock_q | cfg_lock_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) lock_q <= 1'b0;
    else       lock_q <= lock_d;
  end

  assign locked       = lock_q;
  assign cfg_locked_o = lock_q;
`else
  assign locked = 1'b0;
`endif

  assign pin_ok = int'(cfg_pin_i) < NUM_PINS;
  assign sel_ok = int'(cfg_sel_i) < NUM_FUNCS;
  assign wr_ok  = cfg_we_i && pin_ok && sel_ok && !locked;
  assign err_d  = cfg_we_i && !wr_ok;

  always_ff @(posedge clk_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign cfg_err_o = err_q;

  for (genvar p = 0; p < NUM_PINS; p++) begin : g_pin
    logic [NUM_FUNCS-1:0] fo;
    logic [NUM_FUNCS-1:0] foe;
    logic                 we;

    for (genvar f = 0; f < NUM_FUNCS; f++) begin : g_fn
      assign fo[f]  = func_o_i[f*NUM_PINS+p];
      assign foe[f] = func_oe_i[f*NUM_PINS+p];
    end

    assign we = wr_ok && (cfg_pin_i == PIN_W'(p));

    nanosoc_padmux_pin #(
      .NUM_FUNCS (NUM_FUNCS),
      .GAP_CYCLES(GAP_CYCLES),
      .SEL_W     (SEL_W)
    ) u_pin (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .test_mode_i(test_mode_i),
      .we_i       (we),
      .sel_i      (cfg_sel_i),
      .func_o_i   (fo),
      .func_oe_i  (foe),
      .pad_i      (pad_i[p]),
      .busy_o     (cfg_busy_o[p]),
      .cur_sel_o  (cur_sel_o[p*SEL_W +: SEL_W]),
      .func_in_o  (func_in_o[p]),
      .pad_o      (pad_o[p]),
      .pad_e      (pad_e[p])
    );
  end

  assign pad_z = ~pad_e;

endmodule
